// File: rtl/keypad_entry_if.sv
// Bundles the scanner-facing key strobe and the application-facing
// entry/result signals of keypad_entry.
interface keypad_entry_if #(
  parameter int DIGITS  = 4,
  parameter int VALUE_W = 14,
  parameter int CNT_W   = 3
);
  logic [11:0]         scan_in;
  logic                valid_in;
  logic [4*DIGITS-1:0] bcd_out;
  logic [CNT_W-1:0]    digit_cnt;
  logic                busy;
  logic [VALUE_W-1:0]  value_out;
  logic                done;
  logic                err;

  // Key source / result consumer side
  modport master (
    output scan_in, valid_in,
    input  bcd_out, digit_cnt, busy, value_out, done, err
  );

  // keypad_entry side
  modport slave (
    input  scan_in, valid_in,
    output bcd_out, digit_cnt, busy, value_out, done, err
  );
endinterface

// File: rtl/keypad_entry.sv
// Keypad digit entry: collects one-hot keys into a BCD buffer, and on '#'
// converts the buffer to binary one digit per cycle (most significant first).
module keypad_entry #(
  parameter int DIGITS  = 4,
  parameter int VALUE_W = 14,
  parameter int CNT_W   = 3
) (
  input logic          clk,
  input logic          rst,
  keypad_entry_if.slave bus
);
  typedef enum logic {ENTRY = 1'b0, CONV = 1'b1} state_t;

  state_t              state_q, state_d;
  logic [4*DIGITS-1:0] bcd_q, bcd_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [CNT_W-1:0]    idx_q, idx_d;
  logic [VALUE_W-1:0]  acc_q, acc_d;
  logic [VALUE_W-1:0]  val_q, val_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                err_q, err_d;

  logic                key_ok;
  logic [3:0]          dig;
  logic [3:0]          nib;
  logic [VALUE_W-1:0]  sum;

  // Key decode: exactly-one-hot test and digit encode of bits 0..9
  always_comb begin
    key_ok = (bus.scan_in != 12'h000) &&
             ((bus.scan_in & (bus.scan_in - 12'h001)) == 12'h000);
    dig = 4'd0;
    for (int i = 0; i < 10; i++)
      if (bus.scan_in[i]) dig = 4'(i);
  end

  // Conversion datapath: acc*10 + selected nibble, multiply as shift-add
  always_comb begin
    nib = bcd_q[{idx_q, 2'b00} +: 4];
    sum = (acc_q << 3) + (acc_q << 1) + VALUE_W'(nib);
  end

  // Next-state logic for the entry/convert FSM and all registered outputs
  always_comb begin
    state_d = state_q;
    bcd_d   = bcd_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    acc_d   = acc_q;
    val_d   = val_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    case (state_q)
      ENTRY: begin
        if (bus.valid_in) begin
          if (!key_ok) begin
            err_d = 1'b1;
          end else if (bus.scan_in[11]) begin
            if (cnt_q == '0) begin
              err_d = 1'b1;
            end else begin
              state_d = CONV;
              busy_d  = 1'b1;
              acc_d   = '0;
              idx_d   = cnt_q - 1'b1;
            end
          end else if (bus.scan_in[10]) begin
            bcd_d = '0;
            cnt_d = '0;
          end else if (cnt_q == CNT_W'(DIGITS)) begin
            err_d = 1'b1;
          end else begin
            bcd_d = (bcd_q << 4) | (4*DIGITS)'(dig);
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      CONV: begin
        // Keys are refused while converting; conversion carries on regardless
        err_d = bus.valid_in;
        if (idx_q == '0) begin
          val_d   = sum;
          done_d  = 1'b1;
          bcd_d   = '0;
          cnt_d   = '0;
          busy_d  = 1'b0;
          state_d = ENTRY;
        end else begin
          acc_d = sum;
          idx_d = idx_q - 1'b1;
        end
      end
      default: state_d = ENTRY;
    endcase
  end

  // State register; reset also aborts a conversion without a done pulse
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ENTRY;
      bcd_q   <= '0;
      cnt_q   <= '0;
      idx_q   <= '0;
      acc_q   <= '0;
      val_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      bcd_q   <= bcd_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      acc_q   <= acc_d;
      val_q   <= val_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign bus.bcd_out   = bcd_q;
  assign bus.digit_cnt = cnt_q;
  assign bus.busy      = busy_q;
  assign bus.value_out = val_q;
  assign bus.done      = done_q;
  assign bus.err       = err_q;
endmodule

// File: tb/tb_keypad_entry.sv
// Bench for keypad_entry: key-vector table plus hand-written corner sequences;
// expected conversion results go through a scoreboard queue checked on done.
module tb_keypad_entry;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  keypad_entry_if #(.DIGITS(4), .VALUE_W(14), .CNT_W(3)) kif ();
  keypad_entry #(.DIGITS(4), .VALUE_W(14), .CNT_W(3)) dut (
    .clk(clk), .rst(rst), .bus(kif.slave)
  );

  typedef struct {
    logic [11:0] scan;
    logic        err;
    logic [2:0]  cnt;
    logic [15:0] bcd;
    logic        enter;   // '#' that starts a conversion
    int          val;     // expected result when enter is set
  } vec_t;

  vec_t vecs[$];
  int   sb[$];
  int   errors = 0;
  int   checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Drive one key strobe; returns #1 after the edge that samples it
  task automatic press(input logic [11:0] k);
    kif.scan_in  = k;
    kif.valid_in = 1'b1;
    @(posedge clk); #1;
    kif.valid_in = 1'b0;
    kif.scan_in  = 12'h000;
  endtask

  // Scoreboard consumer: every done must match the oldest pushed result
  always @(negedge clk) begin
    if (kif.done) begin
      if (sb.size() == 0) begin
        chk("unexpected_done", 32'(kif.value_out), 32'hFFFF_FFFF);
      end else begin
        chk("sb_value", 32'(kif.value_out), 32'(sb.pop_front()));
      end
      chk("done_err_overlap", 32'(kif.err), 32'd0);
    end
  end

  initial begin
    kif.scan_in  = 12'h000;
    kif.valid_in = 1'b0;

    vecs.push_back('{12'h002, 1'b0, 3'd1, 16'h0001, 1'b0, 0});
    vecs.push_back('{12'h004, 1'b0, 3'd2, 16'h0012, 1'b0, 0});
    vecs.push_back('{12'h008, 1'b0, 3'd3, 16'h0123, 1'b0, 0});
    vecs.push_back('{12'h800, 1'b0, 3'd3, 16'h0123, 1'b1, 123});
    vecs.push_back('{12'h200, 1'b0, 3'd1, 16'h0009, 1'b0, 0});
    vecs.push_back('{12'h200, 1'b0, 3'd2, 16'h0099, 1'b0, 0});
    vecs.push_back('{12'h200, 1'b0, 3'd3, 16'h0999, 1'b0, 0});
    vecs.push_back('{12'h200, 1'b0, 3'd4, 16'h9999, 1'b0, 0});
    vecs.push_back('{12'h020, 1'b1, 3'd4, 16'h9999, 1'b0, 0});
    vecs.push_back('{12'h800, 1'b0, 3'd4, 16'h9999, 1'b1, 9999});
    vecs.push_back('{12'h080, 1'b0, 3'd1, 16'h0007, 1'b0, 0});
    vecs.push_back('{12'h010, 1'b0, 3'd2, 16'h0074, 1'b0, 0});
    vecs.push_back('{12'h400, 1'b0, 3'd0, 16'h0000, 1'b0, 0});
    vecs.push_back('{12'h800, 1'b1, 3'd0, 16'h0000, 1'b0, 0});
    vecs.push_back('{12'h003, 1'b1, 3'd0, 16'h0000, 1'b0, 0});
    vecs.push_back('{12'h001, 1'b0, 3'd1, 16'h0000, 1'b0, 0});
    vecs.push_back('{12'h400, 1'b0, 3'd0, 16'h0000, 1'b0, 0});
    vecs.push_back('{12'h400, 1'b0, 3'd0, 16'h0000, 1'b0, 0});
    vecs.push_back('{12'h000, 1'b1, 3'd0, 16'h0000, 1'b0, 0});
    vecs.push_back('{12'hC00, 1'b1, 3'd0, 16'h0000, 1'b0, 0});
    vecs.push_back('{12'h001, 1'b0, 3'd1, 16'h0000, 1'b0, 0});
    vecs.push_back('{12'h001, 1'b0, 3'd2, 16'h0000, 1'b0, 0});
    vecs.push_back('{12'h080, 1'b0, 3'd3, 16'h0007, 1'b0, 0});
    vecs.push_back('{12'h800, 1'b0, 3'd3, 16'h0007, 1'b1, 7});

    // Reset state
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    chk("rst_bcd",   32'(kif.bcd_out),   32'd0);
    chk("rst_cnt",   32'(kif.digit_cnt), 32'd0);
    chk("rst_busy",  32'(kif.busy),      32'd0);
    chk("rst_value", 32'(kif.value_out), 32'd0);
    chk("rst_done",  32'(kif.done),      32'd0);
    chk("rst_err",   32'(kif.err),       32'd0);

    // Table-driven key vectors
    foreach (vecs[i]) begin
      if (vecs[i].enter) sb.push_back(vecs[i].val);
      press(vecs[i].scan);
      chk($sformatf("v%0d_err", i), 32'(kif.err),       32'(vecs[i].err));
      chk($sformatf("v%0d_cnt", i), 32'(kif.digit_cnt), 32'(vecs[i].cnt));
      chk($sformatf("v%0d_bcd", i), 32'(kif.bcd_out),   32'(vecs[i].bcd));
      if (vecs[i].enter) begin
        chk($sformatf("v%0d_busy0", i), 32'(kif.busy), 32'd1);
        for (int k = 1; k <= int'(vecs[i].cnt); k++) begin
          @(posedge clk); #1;
          chk($sformatf("v%0d_busy%0d", i, k), 32'(kif.busy), 32'(k != int'(vecs[i].cnt)));
          chk($sformatf("v%0d_done%0d", i, k), 32'(kif.done), 32'(k == int'(vecs[i].cnt)));
        end
        chk($sformatf("v%0d_clr_cnt", i), 32'(kif.digit_cnt), 32'd0);
        chk($sformatf("v%0d_clr_bcd", i), 32'(kif.bcd_out),   32'd0);
        @(posedge clk); #1;
        chk($sformatf("v%0d_done_pulse", i), 32'(kif.done),      32'd0);
        chk($sformatf("v%0d_hold", i),       32'(kif.value_out), 32'(vecs[i].val));
      end else if (vecs[i].err) begin
        @(posedge clk); #1;
        chk($sformatf("v%0d_err_pulse", i), 32'(kif.err), 32'd0);
      end
    end

    // Key during conversion, then reset aborts it with no done
    press(12'h020);
    press(12'h040);
    press(12'h800);
    chk("ab_busy", 32'(kif.busy), 32'd1);
    press(12'h002);
    chk("ab_err",  32'(kif.err),     32'd1);
    chk("ab_bcd",  32'(kif.bcd_out), 32'h0056);
    chk("ab_busy2", 32'(kif.busy),   32'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("ab_rst_bcd",   32'(kif.bcd_out),   32'd0);
    chk("ab_rst_cnt",   32'(kif.digit_cnt), 32'd0);
    chk("ab_rst_busy",  32'(kif.busy),      32'd0);
    chk("ab_rst_done",  32'(kif.done),      32'd0);
    chk("ab_rst_err",   32'(kif.err),       32'd0);
    chk("ab_rst_value", 32'(kif.value_out), 32'd0);
    @(posedge clk); #1;
    chk("ab_no_done", 32'(kif.done), 32'd0);

    // Single digit after reset: done one edge after '#'
    press(12'h100);
    chk("s8_cnt", 32'(kif.digit_cnt), 32'd1);
    chk("s8_bcd", 32'(kif.bcd_out),   32'h0008);
    sb.push_back(8);
    press(12'h800);
    @(posedge clk); #1;
    chk("s8_done", 32'(kif.done), 32'd1);
    chk("s8_val",  32'(kif.value_out), 32'd8);

    // Key right after done is taken normally
    press(12'h008);
    chk("after_done_cnt", 32'(kif.digit_cnt), 32'd1);
    chk("after_done_bcd", 32'(kif.bcd_out),   32'h0003);

    repeat (3) @(posedge clk);
    #1;
    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Safety bound on the whole run
  initial begin
    #200000;
    $display("FAIL timeout: run did not complete");
    $fatal(1);
  end
endmodule
